// File: rtl/space_pkg.sv
// Shared types and constants for the invader datapath.
//   wave_state_t : formation controller states
//   MAX_WAVE     : last wave; clearing it ends the game
//   N_INV_DEF    : default invaders per wave
//   COORD_W      : width of the march X/Y coordinates
package space_pkg;
  typedef enum logic [1:0] {PLAY, CLEAR, OVER} wave_state_t;

  localparam int MAX_WAVE  = 8;
  localparam int N_INV_DEF = 16;
  localparam int COORD_W   = 8;

  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/tick_sync.sv
// Brings the divider's slow tick square wave into the clkin domain and
// turns each rising edge into a single-cycle step pulse.
//   clkin, reset : clock, synchronous active-high reset
//   tick_in      : asynchronous slow square wave
//   step         : one clkin cycle high per tick_in rising edge
module tick_sync (
  input  logic clkin,
  input  logic reset,
  input  logic tick_in,
  output logic step
);
  // [0],[1] are the metastability filter; [2] is the previous value of [1].
  logic [2:0] sync_pipe;

  always_ff @(posedge clkin) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[1:0], tick_in};
  end

  assign step = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/wave_ctrl.sv
// Invader formation controller: owns the alive mask, march position and
// direction, wave number and end-of-game flag, strobes the divider's
// active-low next-level input when a wave is cleared, and makes the buzzer
// tone while the divider enables it.
//   clkin, reset        : clock, synchronous active-high reset
//   tick_in             : divider march tick (asynchronous)
//   buz_in              : divider buzzer enable
//   hit_valid, hit_idx  : shot hit strobe and invader index
//   pn                  : active-low one-cycle next-level strobe
//   alive               : 1 = invader alive
//   march_x/y, march_dir: formation origin and direction (1 = right)
//   wave_num            : current wave 1..8
//   game_over           : sticky end-of-game flag
//   buzzer_pin          : tone output
module wave_ctrl
  import space_pkg::*;
#(
  parameter int           N_INV       = N_INV_DEF,
  parameter logic [7:0]   X_MAX       = 8'd200,
  parameter logic [7:0]   STEP_X      = 8'd4,
  parameter logic [7:0]   STEP_Y      = 8'd8,
  parameter logic [7:0]   Y_LIMIT     = 8'd160,
  parameter int           CLEAR_TICKS = 2,
  parameter int           TONE_HALF   = 25000
) (
  input  logic                     clkin,
  input  logic                     reset,
  input  logic                     tick_in,
  input  logic                     buz_in,
  input  logic                     hit_valid,
  input  logic [$clog2(N_INV)-1:0] hit_idx,
  output logic                     pn,
  output logic [N_INV-1:0]         alive,
  output logic [7:0]               march_x,
  output logic [7:0]               march_y,
  output logic                     march_dir,
  output logic [3:0]               wave_num,
  output logic                     game_over,
  output logic                     buzzer_pin
);
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic step;

  tick_sync u_tick_sync (
    .clkin  (clkin),
    .reset  (reset),
    .tick_in(tick_in),
    .step   (step)
  );

  wave_state_t state_q, state_n;
  logic [N_INV-1:0] alive_n, alive_hit;
  logic [7:0]       x_n, y_n, clr_cnt, clr_cnt_n, clr_dec;
  logic             dir_n, pn_n, go_n;
  logic [3:0]       wave_n;
  logic [8:0]       x_sum, y_sum;
  logic             bounce, land;

  // March arithmetic is done one bit wider so edge tests cannot wrap.
  assign x_sum   = {1'b0, march_x} + {1'b0, STEP_X};
  assign y_sum   = {1'b0, march_y} + {1'b0, STEP_Y};
  assign bounce  = march_dir ? (x_sum > {1'b0, X_MAX}) : (march_x < STEP_X);
  assign land    = step && bounce && (y_sum >= {1'b0, Y_LIMIT});
  assign clr_dec = clr_cnt - 8'd1;

  always_comb begin
    alive_hit = alive;
    if (hit_valid && (int'(hit_idx) < N_INV)) alive_hit[hit_idx] = 1'b0;
  end

  always_comb begin
    state_n   = state_q;
    alive_n   = alive;
    x_n       = march_x;
    y_n       = march_y;
    dir_n     = march_dir;
    wave_n    = wave_num;
    go_n      = game_over;
    clr_cnt_n = clr_cnt;
    pn_n      = 1'b1;
    unique case (state_q)
      PLAY: begin
        alive_n = alive_hit;
        if (step) begin
          if (bounce) begin
            y_n   = y_sum[7:0];
            dir_n = ~march_dir;
          end else if (march_dir) begin
            x_n = x_sum[7:0];
          end else begin
            x_n = march_x - STEP_X;
          end
        end
        // A last kill outranks a simultaneous landing.
        if (alive_hit == '0) begin
          state_n   = CLEAR;
          pn_n      = 1'b0;
          clr_cnt_n = 8'(CLEAR_TICKS);
        end else if (land) begin
          state_n = OVER;
          go_n    = 1'b1;
        end
      end
      CLEAR: begin
        if (step) begin
          clr_cnt_n = clr_dec;
          if (clr_dec == 8'd0) begin
            if (wave_num == 4'(MAX_WAVE)) begin
              state_n = OVER;
              go_n    = 1'b1;
            end else begin
              state_n = PLAY;
              wave_n  = wave_num + 4'd1;
              alive_n = '1;
              x_n     = 8'd0;
              y_n     = 8'd0;
              dir_n   = 1'b1;
            end
          end
        end
      end
      OVER: go_n = 1'b1;
      default: state_n = PLAY;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= PLAY;
      alive     <= '1;
      march_x   <= 8'd0;
      march_y   <= 8'd0;
      march_dir <= 1'b1;
      wave_num  <= 4'd1;
      game_over <= 1'b0;
      clr_cnt   <= 8'd0;
      pn        <= 1'b1;
    end else begin
      state_q   <= state_n;
      alive     <= alive_n;
      march_x   <= x_n;
      march_y   <= y_n;
      march_dir <= dir_n;
      wave_num  <= wave_n;
      game_over <= go_n;
      clr_cnt   <= clr_cnt_n;
      pn        <= pn_n;
    end
  end

  // Tone: free-running half-period counter, independent of the FSM.
  logic [TW-1:0] tone_cnt;

  always_ff @(posedge clkin) begin
    if (reset || !buz_in) begin
      tone_cnt   <= '0;
      buzzer_pin <= 1'b0;
    end else if (tone_cnt == TW'(TONE_HALF - 1)) begin
      tone_cnt   <= '0;
      buzzer_pin <= ~buzzer_pin;
    end else begin
      tone_cnt   <= tone_cnt + TW'(1);
    end
  end
endmodule
